// File: rtl/stencil_ctrl_pkg.sv
// Shared types and default widths for the stencil frame controller.
package stencil_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/stencil_frame_controller_frame_counter.sv
// Saturating pixel counter with clear, increment and compare against a frame target.
module frame_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             hit,
    output logic             hit_next
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Next value: increment unless already pinned at all-ones.
    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && (cnt_q != '1))
            cnt_nxt = cnt_q + CNT_W'(1);
    end

    // Count register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else
            cnt_q <= cnt_nxt;
    end

    assign count    = cnt_q;
    assign hit      = (cnt_q == target);
    // True when the increment taken this cycle lands exactly on the target.
    assign hit_next = inc && (cnt_nxt == target);

endmodule

// File: rtl/stencil_frame_controller.sv
// Frame sequencer for a statically scheduled CGRA stencil accelerator:
// flushes it, feeds host pixels on read_en, forwards and counts its writes.
module stencil_frame_controller
    import stencil_ctrl_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_in_pixels,
    input  logic [CNT_W-1:0]  cfg_out_pixels,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              accel_flush,
    input  logic              accel_read_en,
    output logic [DATA_W-1:0] accel_read_data,
    input  logic              accel_write_valid,
    input  logic [DATA_W-1:0] accel_write,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err_underrun,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count
);

    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e state_q, state_nxt;

    logic [CNT_W-1:0]  in_pixels_q;
    logic [CNT_W-1:0]  out_pixels_q;
    logic [FL_W-1:0]   flush_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              err_underrun_q;
    logic              err_timeout_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    logic start_acc;
    logic in_inc;
    logic fwd;
    logic flush_last;
    logic tmo_expire;
    logic in_hit, in_hit_next;
    logic out_hit, out_hit_next_unused;

    assign start_acc  = (state_q == IDLE) && cfg_start;
    assign in_inc     = (state_q == RUN) && accel_read_en;
    // Only forward writes while a frame is streaming and the quota is not met.
    assign fwd        = ((state_q == RUN) || (state_q == DRAIN)) && accel_write_valid && !out_hit;
    assign flush_last = (flush_cnt_q == FL_LAST);
    assign tmo_expire = (state_q == DRAIN) && !accel_write_valid && (tmo_q == TMO_LAST);

    frame_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .inc      (in_inc),
        .target   (in_pixels_q),
        .count    (in_count),
        .hit      (in_hit),
        .hit_next (in_hit_next)
    );

    frame_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc),
        .inc      (fwd),
        .target   (out_pixels_q),
        .count    (out_count),
        .hit      (out_hit),
        .hit_next (out_hit_next_unused)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:  if (cfg_start) state_nxt = FLUSH;
            // Counters were cleared on start, so in_hit here means a zero-input frame.
            FLUSH: if (flush_last) state_nxt = in_hit ? DRAIN : RUN;
            RUN:   if (in_hit_next) state_nxt = DRAIN;
            DRAIN: if (out_hit || tmo_expire) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; the read path is combinational so the accelerator never waits.
    always_comb begin
        host_ready      = 1'b0;
        accel_flush     = 1'b0;
        accel_read_data = '0;
        busy            = (state_q != IDLE);
        done            = 1'b0;
        unique case (state_q)
            FLUSH: accel_flush = 1'b1;
            RUN: begin
                host_ready      = accel_read_en;
                accel_read_data = host_valid ? host_data : '0;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Frame configuration latch and flush-length counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pixels_q  <= '0;
            out_pixels_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (start_acc) begin
                in_pixels_q  <= cfg_in_pixels;
                out_pixels_q <= cfg_out_pixels;
            end
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + FL_W'(1) : '0;
        end
    end

    // Drain watchdog: counts silent DRAIN cycles, restarts on any write.
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_q <= '0;
        else if (start_acc)
            tmo_q <= '0;
        else if (state_q == DRAIN)
            tmo_q <= accel_write_valid ? '0 : tmo_q + TMO_W'(1);
    end

    // Sticky error flags, cleared only by reset or a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else if (start_acc) begin
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            if (in_inc && !host_valid)
                err_underrun_q <= 1'b1;
            if (tmo_expire && !out_hit)
                err_timeout_q <= 1'b1;
        end
    end

    // Registered output stream; excess writes beyond the quota are dropped silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= fwd;
            if (fwd)
                out_data_q <= accel_write;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign err_underrun = err_underrun_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_stencil_frame_controller.sv
// Directed bench for stencil_frame_controller.
module tb_stencil_frame_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [31:0] cfg_in_pixels, cfg_out_pixels;
    logic [15:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        accel_flush;
    logic        accel_read_en;
    logic [15:0] accel_read_data;
    logic        accel_write_valid;
    logic [15:0] accel_write;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy, done, err_underrun, err_timeout;
    logic [31:0] in_count, out_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stencil_frame_controller #(
        .DATA_W(16), .CNT_W(32), .FLUSH_CYCLES(4), .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_in_pixels(cfg_in_pixels), .cfg_out_pixels(cfg_out_pixels),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .accel_flush(accel_flush), .accel_read_en(accel_read_en),
        .accel_read_data(accel_read_data), .accel_write_valid(accel_write_valid),
        .accel_write(accel_write), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .err_underrun(err_underrun), .err_timeout(err_timeout),
        .in_count(in_count), .out_count(out_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] ni, input logic [31:0] no);
        cfg_in_pixels  = ni;
        cfg_out_pixels = no;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        while (accel_flush === 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) begin
            accel_read_en = 1'b1; host_valid = 1'b1; host_data = 16'(i + 1);
            tick();
        end
        accel_read_en = 1'b0;
    endtask

    task automatic do_writes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            accel_write_valid = 1'b1; accel_write = 16'(base + i);
            tick();
        end
        accel_write_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || accel_flush !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: busy=%b done=%b flush=%b, want 0 0 0", busy, done, accel_flush);
        end
        tests++; if (in_count !== 32'd0 || out_count !== 32'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_cnt: in=%0d out=%0d ov=%b, want 0 0 0", in_count, out_count, out_valid);
        end
        tests++; if (err_underrun !== 1'b0 || err_timeout !== 1'b0 || host_ready !== 1'b0) begin
            fails++; $display("FAIL reset_err: und=%b tmo=%b rdy=%b, want 0 0 0", err_underrun, err_timeout, host_ready);
        end
    endtask

    task automatic test_nominal();
        int n;
        int dc;
        start_frame(32'd8, 32'd6);
        wait_flush(n);
        tests++; if (n !== 4) begin
            fails++; $display("FAIL nom_flush_len: got %0d cycles, want 4", n);
        end
        for (int i = 0; i < 8; i++) begin
            accel_read_en = 1'b1; host_valid = 1'b1; host_data = 16'(16'h0100 + i);
            if (i == 0) begin
                #1;
                tests++; if (host_ready !== 1'b1 || accel_read_data !== 16'h0100) begin
                    fails++; $display("FAIL nom_read_path: rdy=%b data=%h, want 1 0100", host_ready, accel_read_data);
                end
            end
            tick();
        end
        // Now in DRAIN: read strobes must be ignored.
        #1;
        tests++; if (host_ready !== 1'b0 || in_count !== 32'd8) begin
            fails++; $display("FAIL nom_drain_ignore: rdy=%b in=%0d, want 0 8", host_ready, in_count);
        end
        accel_read_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            accel_write_valid = 1'b1; accel_write = 16'(200 + i);
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== 16'(200 + i)) begin
                fails++; $display("FAIL nom_fwd%0d: ov=%b data=%0d, want 1 %0d", i, out_valid, out_data, 200 + i);
            end
        end
        accel_write_valid = 1'b0;
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dc++;
            tick();
        end
        tests++; if (dc !== 1 || busy !== 1'b0) begin
            fails++; $display("FAIL nom_done: pulses=%0d busy=%b, want 1 0", dc, busy);
        end
        tests++; if (in_count !== 32'd8 || out_count !== 32'd6 || err_underrun !== 1'b0 || err_timeout !== 1'b0) begin
            fails++; $display("FAIL nom_final: in=%0d out=%0d und=%b tmo=%b, want 8 6 0 0",
                              in_count, out_count, err_underrun, err_timeout);
        end
    endtask

    task automatic test_underrun();
        int n;
        int dc;
        start_frame(32'd8, 32'd6);
        wait_flush(n);
        for (int i = 0; i < 8; i++) begin
            accel_read_en = 1'b1;
            host_valid    = (i != 2);
            host_data     = 16'hbeef;
            if (i == 2) begin
                #1;
                tests++; if (accel_read_data !== 16'h0000) begin
                    fails++; $display("FAIL und_zero_data: got %h, want 0000", accel_read_data);
                end
            end
            tick();
            if (i == 2) begin
                tests++; if (err_underrun !== 1'b1) begin
                    fails++; $display("FAIL und_set: got %b, want 1", err_underrun);
                end
            end
        end
        accel_read_en = 1'b0; host_valid = 1'b1;
        tests++; if (in_count !== 32'd8) begin
            fails++; $display("FAIL und_in_count: got %0d, want 8", in_count);
        end
        do_writes(6, 50);
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dc++;
            tick();
        end
        tests++; if (dc !== 1 || err_underrun !== 1'b1) begin
            fails++; $display("FAIL und_done_sticky: pulses=%0d und=%b, want 1 1", dc, err_underrun);
        end
    endtask

    task automatic test_timeout();
        int n;
        start_frame(32'd4, 32'd5);
        tests++; if (err_underrun !== 1'b0) begin
            fails++; $display("FAIL tmo_err_clear: und=%b, want 0", err_underrun);
        end
        wait_flush(n);
        do_reads(4);
        do_writes(2, 70);
        n = 0;
        while (err_timeout !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        tests++; if (n !== 4096) begin
            fails++; $display("FAIL tmo_latency: got %0d cycles, want 4096", n);
        end
        tests++; if (done !== 1'b1 || out_count !== 32'd2) begin
            fails++; $display("FAIL tmo_done: done=%b out=%0d, want 1 2", done, out_count);
        end
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b1) begin
            fails++; $display("FAIL tmo_idle: busy=%b done=%b tmo=%b, want 0 0 1", busy, done, err_timeout);
        end
    endtask

    task automatic test_excess();
        int n;
        int ov;
        start_frame(32'd8, 32'd3);
        wait_flush(n);
        ov = 0;
        for (int i = 0; i < 8; i++) begin
            accel_read_en = 1'b1; host_valid = 1'b1; host_data = 16'(i);
            accel_write_valid = (i < 5);
            accel_write = 16'(300 + i);
            tick();
            if (out_valid === 1'b1) ov++;
            if (i == 0) begin
                tests++; if (out_data !== 16'd300) begin
                    fails++; $display("FAIL exc_first_data: got %0d, want 300", out_data);
                end
            end
        end
        accel_read_en = 1'b0; accel_write_valid = 1'b0;
        tests++; if (ov !== 3 || out_count !== 32'd3) begin
            fails++; $display("FAIL exc_count: ov=%0d out=%0d, want 3 3", ov, out_count);
        end
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL exc_drain: busy=%b done=%b, want 1 0", busy, done);
        end
        tick();
        tests++; if (done !== 1'b1) begin
            fails++; $display("FAIL exc_drain_len: done=%b, want 1", done);
        end
        tick();
        tests++; if (busy !== 1'b0 || err_underrun !== 1'b0 || err_timeout !== 1'b0) begin
            fails++; $display("FAIL exc_final: busy=%b und=%b tmo=%b, want 0 0 0", busy, err_underrun, err_timeout);
        end
    endtask

    task automatic test_zero();
        int t;
        accel_read_en = 1'b1; accel_write_valid = 1'b1; host_valid = 1'b1;
        start_frame(32'd0, 32'd0);
        t = 0;
        tests++; if (accel_flush !== 1'b1 || host_ready !== 1'b0) begin
            fails++; $display("FAIL zero_flush: flush=%b rdy=%b, want 1 0", accel_flush, host_ready);
        end
        tick(); t++;
        cfg_in_pixels = 32'd7; cfg_out_pixels = 32'd7; cfg_start = 1'b1;
        tick(); t++;
        cfg_start = 1'b0;
        while (done !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        tests++; if (t !== 5) begin
            fails++; $display("FAIL zero_latency: done after %0d cycles, want 5", t);
        end
        accel_read_en = 1'b0; accel_write_valid = 1'b0;
        tick();
        tests++; if (busy !== 1'b0 || in_count !== 32'd0 || out_count !== 32'd0) begin
            fails++; $display("FAIL zero_final: busy=%b in=%0d out=%0d, want 0 0 0", busy, in_count, out_count);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int dc;
        start_frame(32'd8, 32'd6);
        wait_flush(n);
        do_reads(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if (busy !== 1'b0 || in_count !== 32'd0 || accel_flush !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid: busy=%b in=%0d flush=%b ov=%b, want 0 0 0 0",
                              busy, in_count, accel_flush, out_valid);
        end
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) dc++;
            tick();
        end
        tests++; if (dc !== 0) begin
            fails++; $display("FAIL rst_no_done: pulses=%0d, want 0", dc);
        end
        start_frame(32'd2, 32'd1);
        wait_flush(n);
        do_reads(2);
        do_writes(1, 90);
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) dc++;
            tick();
        end
        tests++; if (dc !== 1 || in_count !== 32'd2 || out_count !== 32'd1) begin
            fails++; $display("FAIL rst_clean_frame: pulses=%0d in=%0d out=%0d, want 1 2 1", dc, in_count, out_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_in_pixels = '0; cfg_out_pixels = '0;
        host_data = '0; host_valid = 1'b0; accel_read_en = 1'b0;
        accel_write_valid = 1'b0; accel_write = '0;
        test_reset();
        test_nominal();
        test_underrun();
        test_timeout();
        test_excess();
        test_zero();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
